// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control and the multiply/divide sequencer.
package alu_ctrl_pkg;

  localparam logic [1:0] AluOpMem = 2'b00;
  localparam logic [1:0] AluOpBeq = 2'b01;
  localparam logic [1:0] AluOpR   = 2'b10;

  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnSra   = 6'b000011;
  localparam logic [5:0] FnSllv  = 6'b000100;
  localparam logic [5:0] FnSrlv  = 6'b000110;
  localparam logic [5:0] FnSrav  = 6'b000111;
  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMthi  = 6'b010001;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMtlo  = 6'b010011;
  localparam logic [5:0] FnMult  = 6'b011000;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDiv   = 6'b011010;
  localparam logic [5:0] FnDivu  = 6'b011011;
  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSltu  = 6'b101011;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluNor  = 4'b1100;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} md_state_e;

  function automatic logic is_hilo_fn(input logic [5:0] f);
    return f inside {FnMfhi, FnMthi, FnMflo, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu};
  endfunction

endpackage

// File: rtl/md_seq.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
module md_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic [5:0]        func_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(DATA_W);

  md_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d, mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic                  is_div_q, is_div_d, done_q, done_d;

  logic                  f_mul, f_div, f_signed, sign_a, sign_b, div_zero;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic [DATA_W:0]       mul_sum, rem_sh, div_diff;
  logic [2*DATA_W-1:0]   mul_next, div_next, prod_fix;

  assign f_mul    = (func_i == FnMult) || (func_i == FnMultu);
  assign f_div    = (func_i == FnDiv) || (func_i == FnDivu);
  assign f_signed = (func_i == FnMult) || (func_i == FnDiv);
  assign sign_a   = f_signed & op_a_i[DATA_W-1];
  assign sign_b   = f_signed & op_b_i[DATA_W-1];
  assign abs_a    = sign_a ? -op_a_i : op_a_i;
  assign abs_b    = sign_b ? -op_b_i : op_b_i;
  assign div_zero = f_div & (op_b_i == '0);

  // acc = {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mag_a_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};

  // acc = {remainder, dividend bits shifting into quotient}; borrow bit means no subtract
  assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_diff = rem_sh - {1'b0, mag_b_q};
  assign div_next = div_diff[DATA_W] ?
                    {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0} :
                    {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

  assign prod_fix = neg_q_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_i) begin
          if (func_i == FnMthi) hi_d = op_a_i;
          if (func_i == FnMtlo) lo_d = op_a_i;
          if (f_mul || f_div) begin
            state_d  = f_mul ? StMul : StDiv;
            is_div_d = f_div;
            cnt_d    = CntInit;
            neg_q_d  = sign_a ^ sign_b;
            neg_r_d  = sign_a;
            dz_d     = div_zero;
            // Divide-by-zero keeps raw op_a so HI can return it unchanged
            mag_a_d  = div_zero ? op_a_i : abs_a;
            mag_b_d  = abs_b;
            acc_d    = {{DATA_W{1'b0}}, f_mul ? abs_b : abs_a};
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (state_q == StMul) ? mul_next : div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          lo_d = '1;
          hi_d = mag_a_q;
        end else begin
          lo_d = neg_q_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU/shift/jr decode plus HI/LO hazard stall around the mult/div sequencer.
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        alu_ctrl,
  output logic              jr,
  output logic              shift_len,
  output logic              shift_ren,
  output logic              shift_arith,
  output logic              shift_var,
  output logic              shift_data2reg,
  output logic              hilo_data2reg,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic              md_stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic hilo_cls, accept;

  always_comb begin
    alu_ctrl       = AluAnd;
    jr             = 1'b0;
    shift_len      = 1'b0;
    shift_ren      = 1'b0;
    shift_arith    = 1'b0;
    shift_var      = 1'b0;
    shift_data2reg = 1'b0;
    hilo_data2reg  = 1'b0;
    unique case (alu_op)
      AluOpMem: alu_ctrl = AluAdd;
      AluOpBeq: alu_ctrl = AluSub;
      AluOpR: begin
        unique case (func)
          FnAdd, FnAddu: alu_ctrl = AluAdd;
          FnSub, FnSubu: alu_ctrl = AluSub;
          FnAnd:         alu_ctrl = AluAnd;
          FnOr:          alu_ctrl = AluOr;
          FnXor:         alu_ctrl = AluXor;
          FnNor:         alu_ctrl = AluNor;
          FnSlt:         alu_ctrl = AluSlt;
          FnSltu:        alu_ctrl = AluSltu;
          FnJr:          jr = 1'b1;
          FnSll:  begin shift_len = 1'b1; shift_data2reg = 1'b1; end
          FnSrl:  begin shift_ren = 1'b1; shift_data2reg = 1'b1; end
          FnSra:  begin shift_ren = 1'b1; shift_arith = 1'b1; shift_data2reg = 1'b1; end
          FnSllv: begin shift_len = 1'b1; shift_var = 1'b1; shift_data2reg = 1'b1; end
          FnSrlv: begin shift_ren = 1'b1; shift_var = 1'b1; shift_data2reg = 1'b1; end
          FnSrav: begin
            shift_ren      = 1'b1;
            shift_arith    = 1'b1;
            shift_var      = 1'b1;
            shift_data2reg = 1'b1;
          end
          FnMfhi, FnMflo: hilo_data2reg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    hilo_rdata = '0;
    if (alu_op == AluOpR && func == FnMfhi) hilo_rdata = hi;
    if (alu_op == AluOpR && func == FnMflo) hilo_rdata = lo;
  end

  // Only HI/LO-class instructions wait on the sequencer; everything else flows
  assign hilo_cls = ex_valid & (alu_op == AluOpR) & is_hilo_fn(func);
  assign md_stall = hilo_cls & md_busy;
  assign accept   = hilo_cls & ~md_busy & ~rst;

  md_seq #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .accept_i(accept),
    .func_i  (func),
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed self-checking bench for alu_ctrl_md (DATA_W = 32).
module tb_alu_ctrl_md;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  func = 6'b100000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  alu_ctrl;
  logic        jr, shift_len, shift_ren, shift_arith, shift_var, shift_data2reg, hilo_data2reg;
  logic [31:0] hilo_rdata, hi, lo;
  logic        md_stall, md_busy, md_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_md #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .alu_op        (alu_op),
    .func          (func),
    .op_a          (op_a),
    .op_b          (op_b),
    .alu_ctrl      (alu_ctrl),
    .jr            (jr),
    .shift_len     (shift_len),
    .shift_ren     (shift_ren),
    .shift_arith   (shift_arith),
    .shift_var     (shift_var),
    .shift_data2reg(shift_data2reg),
    .hilo_data2reg (hilo_data2reg),
    .hilo_rdata    (hilo_rdata),
    .md_stall      (md_stall),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .hi            (hi),
    .lo            (lo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one HI/LO-class instruction for the accept edge, then drop it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1;
    alu_op   = 2'b10;
    func     = f;
    op_a     = a;
    op_b     = b;
    step();
    ex_valid = 1'b0;
    func     = 6'b100000;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!md_done && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({md_busy, md_done, md_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {md_busy, md_done, md_stall});
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_decode();
    logic [18:0] tab [23];
    logic [10:0] obs;
    // {alu_op, func, alu_ctrl, jr, len, ren, arith, var, sh2reg, hilo2reg}
    tab = '{
      {2'b10, 6'b100000, 4'b0010, 7'b0000000}, {2'b10, 6'b100001, 4'b0010, 7'b0000000},
      {2'b10, 6'b100010, 4'b0110, 7'b0000000}, {2'b10, 6'b100011, 4'b0110, 7'b0000000},
      {2'b10, 6'b100100, 4'b0000, 7'b0000000}, {2'b10, 6'b100101, 4'b0001, 7'b0000000},
      {2'b10, 6'b100110, 4'b0011, 7'b0000000}, {2'b10, 6'b100111, 4'b1100, 7'b0000000},
      {2'b10, 6'b101010, 4'b0111, 7'b0000000}, {2'b10, 6'b101011, 4'b1000, 7'b0000000},
      {2'b10, 6'b001000, 4'b0000, 7'b1000000}, {2'b10, 6'b000000, 4'b0000, 7'b0100010},
      {2'b10, 6'b000010, 4'b0000, 7'b0010010}, {2'b10, 6'b000011, 4'b0000, 7'b0011010},
      {2'b10, 6'b000100, 4'b0000, 7'b0100110}, {2'b10, 6'b000110, 4'b0000, 7'b0010110},
      {2'b10, 6'b000111, 4'b0000, 7'b0011110}, {2'b10, 6'b010000, 4'b0000, 7'b0000001},
      {2'b10, 6'b010010, 4'b0000, 7'b0000001}, {2'b10, 6'b111111, 4'b0000, 7'b0000000},
      {2'b00, 6'b000111, 4'b0010, 7'b0000000}, {2'b01, 6'b100000, 4'b0110, 7'b0000000},
      {2'b11, 6'b000111, 4'b0000, 7'b0000000}
    };
    ex_valid = 1'b0;
    for (int i = 0; i < 23; i++) begin
      alu_op = tab[i][18:17];
      func   = tab[i][16:11];
      #1;
      obs = {alu_ctrl, jr, shift_len, shift_ren, shift_arith, shift_var, shift_data2reg,
             hilo_data2reg};
      checks++;
      if (obs !== tab[i][10:0]) begin
        errors++;
        $display("FAIL decode op=%b func=%b got %b want %b", alu_op, func, obs, tab[i][10:0]);
      end
    end
    alu_op = 2'b10;
    func   = 6'b100000;
  endtask

  task automatic test_mult();
    int n = 0;
    int busy_cnt = 0;
    issue(6'b011000, 32'hFFFF_FFFD, 32'd7);
    while (!md_done && n < 100) begin
      if (md_busy) busy_cnt++;
      step();
      n++;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL mult_latency got %0d want 33", n);
    end
    checks++;
    if (busy_cnt != 33 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_busy got %0d cycles busy_now=%b want 33 cycles busy_now=0",
               busy_cnt, md_busy);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
    step();
    checks++;
    if (md_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b want 0", md_done);
    end
  endtask

  task automatic test_div_cases();
    // {func, op_a, op_b, hi, lo}
    logic [133:0] tab [5];
    int n;
    tab = '{
      {6'b011011, 32'd100,        32'd7,          32'd2,          32'd14},
      {6'b011010, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD},
      {6'b011010, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF},
      {6'b011010, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000},
      {6'b011000, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0}
    };
    for (int i = 0; i < 5; i++) begin
      issue(tab[i][133:128], tab[i][127:96], tab[i][95:64]);
      wait_done(n);
      checks++;
      if (n != 33 || hi !== tab[i][63:32] || lo !== tab[i][31:0]) begin
        errors++;
        $display("FAIL md_case%0d got n=%0d %h_%h want n=33 %h_%h", i, n, hi, lo,
                 tab[i][63:32], tab[i][31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int stall_cnt = 0;
    issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ex_valid = 1'b1;
    func     = 6'b010010;
    for (int k = 0; k < 33; k++) begin
      if (k == 5) begin
        func = 6'b100000;
        #1;
        checks++;
        if (md_stall !== 1'b0 || alu_ctrl !== 4'b0010) begin
          errors++;
          $display("FAIL add_no_stall got stall=%b ctrl=%b want 0/0010", md_stall, alu_ctrl);
        end
        func = 6'b010010;
        #1;
      end
      if (md_stall) stall_cnt++;
      step();
    end
    checks++;
    if (stall_cnt != 33) begin
      errors++;
      $display("FAIL mflo_stall_cycles got %0d want 33", stall_cnt);
    end
    checks++;
    if (md_stall !== 1'b0 || hilo_rdata !== 32'h1 || hi !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mflo_issue got stall=%b rdata=%h hi=%h want 0/00000001/fffffffe",
               md_stall, hilo_rdata, hi);
    end
    step();
    ex_valid = 1'b0;
    func     = 6'b100000;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(6'b011010, 32'd100, 32'd7);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (md_busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b %h_%h want 0 0_0", md_busy, hi, lo);
    end
    repeat (40) begin
      if (md_done) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_mt_mf();
    issue(6'b010011, 32'h55, 32'h0);
    issue(6'b010001, 32'hAA, 32'h0);
    ex_valid = 1'b1;
    alu_op   = 2'b10;
    func     = 6'b010010;
    #1;
    checks++;
    if (hilo_rdata !== 32'h55 || hilo_data2reg !== 1'b1 || md_stall !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_mflo got %h d2r=%b stall=%b want 00000055/1/0", hilo_rdata,
               hilo_data2reg, md_stall);
    end
    func = 6'b010000;
    #1;
    checks++;
    if (hilo_rdata !== 32'hAA) begin
      errors++;
      $display("FAIL mthi_mfhi got %h want 000000aa", hilo_rdata);
    end
    ex_valid = 1'b0;
    func     = 6'b100000;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div_cases();
    test_back_to_back();
    test_reset_mid();
    test_mt_mf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
- Parametrised next-generation EX-stage ALU control with an integrated iterative multiply/divide sequencer.
- Decodes alu_op/func into ALU, shift and jr controls, covering the full R-type arithmetic, logic and shift set.
- Runs MULT/MULTU/DIV/DIVU over DATA_W cycles into HI/LO registers.
- Generates the EX-stage stall for HI/LO hazards. Sits between the main control unit and the ALU/shifter/writeback mux.

Parameters:
- DATA_W, 32, operand width and HI/LO width; must be even and ≥ 4.
- CNT_W, $clog2(DATA_W)+1, iteration counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- alu_op  in  2  00 = lw/sw, 01 = beq, 10 = R-type, 11 = reserved.
- func  in  6  R-type funct field.
- op_a  in  DATA_W  rs value.
- op_b  in  DATA_W  rt value.
- alu_ctrl  out  4  ALU operation code.
- jr  out  1  jump-register.
- shift_len / shift_ren  out  1  left / right shift enable.
- shift_arith  out  1  arithmetic right shift.
- shift_var  out  1  shift amount taken from rs, not shamt.
- shift_data2reg  out  1  writeback selects shifter.
- hilo_data2reg  out  1  writeback selects hilo_rdata.
- hilo_rdata  out  DATA_W  HI for MFHI, LO for MFLO, else 0.
- md_stall  out  1  hold IF/ID/EX this cycle.
- md_busy  out  1  sequencer not IDLE.
- md_done  out  1  one-cycle pulse when HI/LO are written by a mult/div.
- hi, lo  out  DATA_W  architectural HI/LO.

Behaviour:
- Decode (combinational):
  - Default all controls 0; alu_op 00 → 0010; alu_op 01 → 0110; alu_op 11 → defaults.
  - ALU codes for alu_op 10: ADD/ADDU → 0010; SUB/SUBU → 0110; AND → 0000; OR → 0001; XOR (100110) → 0011; NOR (100111) → 1100; SLT → 0111; SLTU (101011) → 1000.
  - Jump: JR (001000) → jr.
  - Shifts (shift_data2reg = 1 for all):
    - SLL 000000 → len.
    - SRL 000010 → ren.
    - SRA 000011 → ren + arith.
    - SLLV 000100 → len + var.
    - SRLV 000110 → ren + var.
    - SRAV 000111 → ren + arith + var.
  - MFHI 010000 / MFLO 010010 → hilo_data2reg = 1.
  - Unlisted funct → defaults.
- HI/LO-class instruction: ex_valid & alu_op==10 & func ∈ {MFHI, MTHI, MFLO, MTLO, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011}.
- md_stall = HI/LO-class & md_busy. Non-HI/LO instructions never stall.
- Accept = HI/LO-class & !md_busy & !rst.
  - MTHI / MTLO: hi / lo ← op_a at that edge.
  - MFHI / MFLO read the current registers; the value written at an edge is visible the following cycle.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL or DIV on accept of a mult/div.
  - At the accept edge:
    - Latch |op_a| and |op_b| (signed ops) or raw values (unsigned ops).
    - Latch neg_q = sign_a ^ sign_b and neg_r = sign_a (both 0 for unsigned).
    - Latch div-by-zero flag; counter ← DATA_W.
  - MUL: one shift-add step per cycle into a 2·DATA_W accumulator; counter decrements; → FIX when counter reaches 1.
  - DIV: one restoring step per cycle; same counter rule.
  - FIX:
    - MUL: {hi,lo} ← neg_q ? -acc : acc.
    - DIV: lo ← neg_q ? -q : q; hi ← neg_r ? -r : r.
    - md_done = 1; → IDLE.
- Latency: accept at edge T; iterate T+1..T+DATA_W; FIX at T+DATA_W+1. md_busy is registered and deasserts at T+DATA_W+2, so a dependent MFLO issues then.
- Boundary cases:
  - Divide by zero: lo ← all ones, hi ← original op_a; no sign fix.
  - DIV of MIN by -1: lo = MIN (wraps), hi = 0.
  - MULT of MIN·MIN yields the exact 2·DATA_W product.
  - Unsigned ops use full-width operands; no overflow trap.
- Reset (synchronous, dominates everything, including mid-operation):
  - State → IDLE; hi, lo, acc, counter → 0.
  - md_busy, md_done → 0.
  - The in-flight operation is abandoned and HI/LO are not written.
- An MT* or a new mult/div presented while busy is stalled, never dropped; it is accepted the cycle md_busy falls.

Decomposition:
- Package alu_ctrl_pkg: funct localparams, ALU code localparams (4'b0010 etc.), FSM state enum.
- Sub-module md_seq (FSM, counter, accumulator/divider datapath, HI/LO); alu_ctrl_md keeps decode and stall logic.

Test Plan:
- Decode sweep, alu_op=10, each listed funct → exact control vector (e.g. SRAV → ren=arith=var=data2reg=1, alu_ctrl=0000); alu_op 00/01/11 → 0010/0110/0000.
- MULT op_a=-3, op_b=7 → md_done at T+33; hi=FFFFFFFF, lo=FFFFFFEB; md_busy high exactly 33 cycles.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 5/0 → lo=FFFFFFFF, hi=5.
- MULTU FFFFFFFF·FFFFFFFF then MFLO next cycle → md_stall held through T+33; MFLO issues at T+34 with hilo_rdata=00000001; ADD issued meanwhile → md_stall=0.
- rst asserted at T+10 of a DIV → next cycle IDLE, hi=lo=0, md_done never pulses; MTLO 0x55 then MFLO → 0x55.
